// File: rtl/clk_gen_param_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_param_if
// Description : Control/status bundle for the clk_gen_param divider. The
//               master side is the generator (drives clocks and status);
//               the slave side is the consumer that requests run.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_gen_param_if #(
  parameter int NUM_DIV = 3
);
  logic               run;
  logic [NUM_DIV-1:0] clk_out;
  logic [NUM_DIV-1:0] clk_rise;
  logic               locked;
  logic               running;

  modport master (
    input  run,
    output clk_out,
    output clk_rise,
    output locked,
    output running
  );

  modport slave (
    output run,
    input  clk_out,
    input  clk_rise,
    input  locked,
    input  running
  );
endinterface
`default_nettype wire

// File: rtl/clk_gen_param.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_param
// Description : Parametrised clock divider on clk8f. Output i is clk8f/2^(i+1)
//               taken straight from a counter flop, with a registered
//               rising-edge strobe per output, run/stop control that always
//               stops on the common low phase, and a lock indicator.
//               Optional macro CLK_GEN_SYNC_RUN_EN adds a 2-flop synchroniser
//               on run (adds 2 cycles to every run-related latency).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_param #(
  parameter int NUM_DIV     = 3,
  parameter int LOCK_CYCLES = 2
) (
  input  wire                    clk8f,
  input  wire                    reset,   // asynchronous, active low
  clk_gen_param_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [3:0] C_LOCK_MAX = 4'(LOCK_CYCLES);

  state_t             r_state;
  logic [NUM_DIV-1:0] r_cnt;
  logic [NUM_DIV-1:0] r_rise;
  logic               r_locked;
  logic               r_running;
  logic [3:0]         r_lock_cnt;

  logic               w_run;
  logic [NUM_DIV-1:0] w_cnt_inc;
  logic [NUM_DIV-1:0] w_rise;
  logic               w_wrap;

`ifdef CLK_GEN_SYNC_RUN_EN
  logic r_run_meta;
  logic r_run_sync;

  // Bring the asynchronous run request into the clk8f domain
  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
    end else begin
      r_run_meta <= bus.run;
      r_run_sync <= r_run_meta;
    end
  end

  assign w_run = r_run_sync;
`else
  assign w_run = bus.run;
`endif

  // A bit rises exactly when it is 0 now and 1 after the increment
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_rise    = ~r_cnt & w_cnt_inc;
  assign w_wrap    = &r_cnt;

  // Run/stop FSM, divider counter, strobes and lock tracking
  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rise     <= '0;
      r_locked   <= 1'b0;
      r_running  <= 1'b0;
      r_lock_cnt <= 4'd0;
    end else begin
      r_rise <= '0;
      case (r_state)
        ST_IDLE: begin
          // cnt stays 0 on the start edge so every start is phase-aligned
          r_cnt      <= '0;
          r_locked   <= 1'b0;
          r_lock_cnt <= 4'd0;
          if (w_run) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!w_run && w_wrap) begin
            // Stop request lands on the common low phase: stop right here
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_running  <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= 4'd0;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_rise <= w_rise;
            if (!w_run) begin
              r_state <= ST_STOPPING;
            end
            if (w_wrap && (r_lock_cnt != C_LOCK_MAX)) begin
              r_lock_cnt <= r_lock_cnt + 4'd1;
              if ((r_lock_cnt + 4'd1) == C_LOCK_MAX) begin
                r_locked <= 1'b1;
              end
            end
          end
        end

        ST_STOPPING: begin
          // Keep counting so no high phase is truncated
          r_cnt  <= w_cnt_inc;
          r_rise <= w_rise;
          if (w_wrap) begin
            // The wrap edge wins over a late run re-request
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= 4'd0;
          end else if (w_run) begin
            r_state <= ST_RUN;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_running <= 1'b0;
          r_locked  <= 1'b0;
        end
      endcase
    end
  end

  // Clock outputs come directly from flops
  assign bus.clk_out  = r_cnt;
  assign bus.clk_rise = r_rise;
  assign bus.locked   = r_locked;
  assign bus.running  = r_running;

endmodule
`default_nettype wire
